decode_queue: RTL

- Parametrised instruction-decode buffer between fetch and the ID/EX pipeline register.
- Accepts fetched {pc, inst} pairs over a valid/ready handshake and decodes each into the 12-bit main control word plus exception flags at enqueue.
- Stores results in a DEPTH-entry circular queue and presents the oldest entry to ID with a registered valid/ready handshake.
- Decouples variable-latency AXI fetch from pipeline stalls; supports single-cycle flush on branch mispredict or exception.

---
 rtl/decode_queue_pkg.sv | 125 ++++++++++++
 rtl/decode_ctrl.sv | 70 +++++++
 rtl/decode_queue.sv | 81 ++++++++
 3 files changed

// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: opcode/funct/rt/rs constants, control-word layout and encodings, queue payload type.
package decode_queue_pkg;

    localparam logic [5:0] OP_SPECIAL  = 6'b000000;
    localparam logic [5:0] OP_REGIMM   = 6'b000001;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_BLEZ     = 6'b000110;
    localparam logic [5:0] OP_BGTZ     = 6'b000111;
    localparam logic [5:0] OP_ADDI     = 6'b001000;
    localparam logic [5:0] OP_ADDIU    = 6'b001001;
    localparam logic [5:0] OP_SLTI     = 6'b001010;
    localparam logic [5:0] OP_SLTIU    = 6'b001011;
    localparam logic [5:0] OP_ANDI     = 6'b001100;
    localparam logic [5:0] OP_ORI      = 6'b001101;
    localparam logic [5:0] OP_XORI     = 6'b001110;
    localparam logic [5:0] OP_LUI      = 6'b001111;
    localparam logic [5:0] OP_COP0     = 6'b010000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
    localparam logic [5:0] OP_LB       = 6'b100000;
    localparam logic [5:0] OP_LH       = 6'b100001;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_LBU      = 6'b100100;
    localparam logic [5:0] OP_LHU      = 6'b100101;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_SH       = 6'b101001;
    localparam logic [5:0] OP_SW       = 6'b101011;
    localparam logic [5:0] OP_ALL1     = 6'b111111;

    localparam logic [5:0] F_SLL     = 6'b000000;
    localparam logic [5:0] F_SRL     = 6'b000010;
    localparam logic [5:0] F_SRA     = 6'b000011;
    localparam logic [5:0] F_SLLV    = 6'b000100;
    localparam logic [5:0] F_SRLV    = 6'b000110;
    localparam logic [5:0] F_SRAV    = 6'b000111;
    localparam logic [5:0] F_JR      = 6'b001000;
    localparam logic [5:0] F_JALR    = 6'b001001;
    localparam logic [5:0] F_SYSCALL = 6'b001100;
    localparam logic [5:0] F_BREAK   = 6'b001101;
    localparam logic [5:0] F_MFHI    = 6'b010000;
    localparam logic [5:0] F_MTHI    = 6'b010001;
    localparam logic [5:0] F_MFLO    = 6'b010010;
    localparam logic [5:0] F_MTLO    = 6'b010011;
    localparam logic [5:0] F_MULT    = 6'b011000;
    localparam logic [5:0] F_MULTU   = 6'b011001;
    localparam logic [5:0] F_DIV     = 6'b011010;
    localparam logic [5:0] F_DIVU    = 6'b011011;
    localparam logic [5:0] F_ADD     = 6'b100000;
    localparam logic [5:0] F_ADDU    = 6'b100001;
    localparam logic [5:0] F_SUB     = 6'b100010;
    localparam logic [5:0] F_SUBU    = 6'b100011;
    localparam logic [5:0] F_AND     = 6'b100100;
    localparam logic [5:0] F_OR      = 6'b100101;
    localparam logic [5:0] F_XOR     = 6'b100110;
    localparam logic [5:0] F_NOR     = 6'b100111;
    localparam logic [5:0] F_SLT     = 6'b101010;
    localparam logic [5:0] F_SLTU    = 6'b101011;

    localparam logic [5:0] F2_MADD  = 6'b000000;
    localparam logic [5:0] F2_MADDU = 6'b000001;
    localparam logic [5:0] F2_MUL   = 6'b000010;
    localparam logic [5:0] F2_MSUB  = 6'b000100;
    localparam logic [5:0] F2_MSUBU = 6'b000101;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    localparam logic [4:0] RS_MFC0 = 5'b00000;
    localparam logic [4:0] RS_MTC0 = 5'b00100;
    localparam logic [4:0] RS_ERET = 5'b10000;

    localparam int CB_REGWRITE = 11;
    localparam int CB_REGDST   = 9;
    localparam int CB_ALUSRC   = 8;
    localparam int CB_BRANCH   = 7;
    localparam int CB_MEMWRITE = 6;
    localparam int CB_MEMTOREG = 5;
    localparam int CB_JUMP     = 4;
    localparam int CB_HILO     = 3;
    localparam int CB_JBRAL    = 2;
    localparam int CB_JR       = 1;
    localparam int CB_CP0      = 0;

    localparam logic [11:0] M_REGWRITE  = 12'(1) << CB_REGWRITE;
    localparam logic [11:0] M_REGDST_RD = 12'(1) << CB_REGDST;
    localparam logic [11:0] M_REGDST_RA = 12'(2) << CB_REGDST;
    localparam logic [11:0] M_ALUSRC    = 12'(1) << CB_ALUSRC;
    localparam logic [11:0] M_BRANCH    = 12'(1) << CB_BRANCH;
    localparam logic [11:0] M_MEMWRITE  = 12'(1) << CB_MEMWRITE;
    localparam logic [11:0] M_MEMTOREG  = 12'(1) << CB_MEMTOREG;
    localparam logic [11:0] M_JUMP      = 12'(1) << CB_JUMP;
    localparam logic [11:0] M_HILO      = 12'(1) << CB_HILO;
    localparam logic [11:0] M_JBRAL     = 12'(1) << CB_JBRAL;
    localparam logic [11:0] M_JR        = 12'(1) << CB_JR;
    localparam logic [11:0] M_CP0       = 12'(1) << CB_CP0;

    localparam logic [11:0] CTRL_NONE   = 12'b0;
    localparam logic [11:0] CTRL_RTYPE  = M_REGWRITE | M_REGDST_RD;
    localparam logic [11:0] CTRL_HILO   = M_HILO;
    localparam logic [11:0] CTRL_JR     = M_JR;
    localparam logic [11:0] CTRL_JALR   = M_REGWRITE | M_REGDST_RD | M_JBRAL | M_JR;
    localparam logic [11:0] CTRL_ALUI   = M_REGWRITE | M_ALUSRC;
    localparam logic [11:0] CTRL_BRANCH = M_BRANCH;
    localparam logic [11:0] CTRL_BRAL   = M_REGWRITE | M_REGDST_RA | M_BRANCH | M_JBRAL;
    localparam logic [11:0] CTRL_LOAD   = M_REGWRITE | M_ALUSRC | M_MEMTOREG;
    localparam logic [11:0] CTRL_STORE  = M_ALUSRC | M_MEMWRITE;
    localparam logic [11:0] CTRL_J      = M_JUMP;
    localparam logic [11:0] CTRL_JAL    = M_REGWRITE | M_REGDST_RA | M_JUMP | M_JBRAL;
    localparam logic [11:0] CTRL_MTC0   = M_CP0;
    localparam logic [11:0] CTRL_MFC0   = M_REGWRITE;

    typedef struct packed {
        logic [31:0] inst;
        logic [11:0] ctrl;
        logic        invalid;
        logic        syscall;
        logic        brk;
        logic        eret;
    } payload_t;

endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational instruction -> control word and exception flags.
// SPECIAL2 (MUL/MADD/MSUB) decoding is enabled by defining DECODE_SPECIAL2_EN.
module decode_ctrl
    import decode_queue_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic [11:0] ctrl_o,
    output logic        invalid_o,
    output logic        syscall_o,
    output logic        break_o,
    output logic        eret_o
);
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_bits;
    assign op          = inst_i[31:26];
    assign rs          = inst_i[25:21];
    assign rt          = inst_i[20:16];
    assign funct       = inst_i[5:0];
    assign unused_bits = ^inst_i[15:6];
    always_comb begin
        ctrl_o    = CTRL_NONE;
        invalid_o = 1'b0;
        syscall_o = 1'b0;
        break_o   = 1'b0;
        eret_o    = 1'b0;
        case (op)
            OP_SPECIAL: case (funct)
                F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
                F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_MFHI, F_MFLO: ctrl_o = CTRL_RTYPE;
                F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO: ctrl_o = CTRL_HILO;
                F_JR:      ctrl_o = CTRL_JR;
                F_JALR:    ctrl_o = CTRL_JALR;
                F_SYSCALL: syscall_o = 1'b1;
                F_BREAK:   break_o = 1'b1;
                default:   invalid_o = 1'b1;
            endcase
            OP_REGIMM: case (rt)
                RT_BLTZ, RT_BGEZ:     ctrl_o = CTRL_BRANCH;
                RT_BLTZAL, RT_BGEZAL: ctrl_o = CTRL_BRAL;
                default:              invalid_o = 1'b1;
            endcase
            OP_J:   ctrl_o = CTRL_J;
            OP_JAL: ctrl_o = CTRL_JAL;
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctrl_o = CTRL_BRANCH;
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ctrl_o = CTRL_ALUI;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: ctrl_o = CTRL_LOAD;
            OP_SB, OP_SH, OP_SW: ctrl_o = CTRL_STORE;
            OP_COP0: case (rs)
                RS_MFC0: ctrl_o = CTRL_MFC0;
                RS_MTC0: ctrl_o = CTRL_MTC0;
                RS_ERET: eret_o = 1'b1;
                default: invalid_o = 1'b1;
            endcase
`ifdef DECODE_SPECIAL2_EN
            OP_SPECIAL2: case (funct)
                F2_MUL: ctrl_o = CTRL_RTYPE;
                F2_MADD, F2_MADDU, F2_MSUB, F2_MSUBU: ctrl_o = CTRL_HILO;
                default: invalid_o = 1'b1;
            endcase
`else
            OP_SPECIAL2: invalid_o = 1'b1;
`endif
            OP_ALL1: ctrl_o = CTRL_RTYPE;
            default: invalid_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes fetched {pc, inst} at enqueue and buffers results in a DEPTH-entry circular queue.
// Optional SPECIAL2 decoding via DECODE_SPECIAL2_EN (see decode_ctrl).
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [31:0]                in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [31:0]                out_inst,
    output logic [11:0]                out_ctrl,
    output logic                       out_invalid,
    output logic                       out_syscall,
    output logic                       out_break,
    output logic                       out_eret,
    output logic [$clog2(DEPTH):0]     occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [PC_W-1:0] pc_mem_q [DEPTH];
    payload_t        mem_q [DEPTH];
    payload_t        dec;
    payload_t        head;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            push, pop;
    decode_ctrl u_dec (
        .inst_i    (in_inst),
        .ctrl_o    (dec.ctrl),
        .invalid_o (dec.invalid),
        .syscall_o (dec.syscall),
        .break_o   (dec.brk),
        .eret_o    (dec.eret)
    );
    assign dec.inst  = in_inst;
    assign in_ready  = cnt_q != CW'(DEPTH);
    assign out_valid = cnt_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    always_comb begin
        wr_d  = flush ? '0 : wr_q + PW'(push);
        rd_d  = flush ? '0 : rd_q + PW'(pop);
        cnt_d = flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    // Storage needs no reset: outputs are masked to zero whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            pc_mem_q[wr_q] <= in_pc;
            mem_q[wr_q]    <= dec;
        end
    end
    assign head        = out_valid ? mem_q[rd_q] : '0;
    assign out_pc      = out_valid ? pc_mem_q[rd_q] : '0;
    assign out_inst    = head.inst;
    assign out_ctrl    = head.ctrl;
    assign out_invalid = head.invalid;
    assign out_syscall = head.syscall;
    assign out_break   = head.brk;
    assign out_eret    = head.eret;
    assign occupancy   = cnt_q;
endmodule
